// File: rtl/si_req_pkg.sv
// si_req_pkg: shared types and constants for the SI-get request initiator.
//   - status codes reported on si_req_ctrl.status
//   - controller state enum
//   - request payload struct and the command-byte serialiser
package si_req_pkg;

    localparam int unsigned CMD_LEN    = 18;
    localparam int unsigned HDR_LEN    = 6;
    localparam int unsigned NULL_LEN   = 4;
    localparam logic [7:0]  NULL_BYTE  = 8'hFF;

    localparam int unsigned BYTE_CNT_W = 5;
    localparam int unsigned HDR_CNT_W  = 3;
    localparam int unsigned PAY_CNT_W  = 16;
    localparam int unsigned SEC_LEN_W  = 12;
    localparam int unsigned TICK_W     = 28;
    localparam int unsigned SEC_W      = 8;

    typedef enum logic [2:0] {
        STAT_OK      = 3'd0,
        STAT_NULL    = 3'd1,
        STAT_HDR_ERR = 3'd2,
        STAT_TIMEOUT = 3'd3,
        STAT_LEN_ERR = 3'd4
    } si_status_e;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CMD_SEND   = 3'd1,
        WAIT_REPLY = 3'd2,
        RX_HEAD    = 3'd3,
        DRAIN      = 3'd4,
        RX_DATA    = 3'd5,
        DONE       = 3'd6
    } si_state_e;

    typedef struct packed {
        logic [7:0]  cmd_no;
        logic [7:0]  reply;
        logic [15:0] pkt_no;
        logic [15:0] pkt_total;
        logic [7:0]  sfp_num;
        logic [31:0] ip;
        logic [15:0] port;
        logic [12:0] pid;
        logic [7:0]  table_id;
        logic [7:0]  sec_num;
        logic [7:0]  over_time;
    } si_req_t;

    // Byte idx of the 18-byte command frame; multi-byte fields go MSB first.
    function automatic logic [7:0] cmd_byte(input si_req_t r,
                                            input logic [BYTE_CNT_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:    b = r.cmd_no;
            5'd1:    b = r.reply;
            5'd2:    b = r.pkt_no[15:8];
            5'd3:    b = r.pkt_no[7:0];
            5'd4:    b = r.pkt_total[15:8];
            5'd5:    b = r.pkt_total[7:0];
            5'd6:    b = r.sfp_num;
            5'd7:    b = r.ip[31:24];
            5'd8:    b = r.ip[23:16];
            5'd9:    b = r.ip[15:8];
            5'd10:   b = r.ip[7:0];
            5'd11:   b = r.port[15:8];
            5'd12:   b = r.port[7:0];
            5'd13:   b = {3'b000, r.pid[12:8]};
            5'd14:   b = r.pid[7:0];
            5'd15:   b = r.table_id;
            5'd16:   b = r.sec_num;
            5'd17:   b = r.over_time;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/si_sec_timer.sv
// si_sec_timer: one-second tick generator plus saturating seconds counter.
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_clr      clears tick and seconds counters
//   i_en       counting enable
//   o_sec_cnt  whole seconds elapsed since the last clear
module si_sec_timer
    import si_req_pkg::*;
#(
    parameter logic [TICK_W-1:0] ONE_SECOND_CNT = 28'h9502F90
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [SEC_W-1:0] o_sec_cnt
);

    logic [TICK_W-1:0] r_tick_cnt;
    logic [SEC_W-1:0]  r_sec_cnt;

    // Tick counter wraps at ONE_SECOND_CNT; each wrap adds one second.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_tick_cnt <= '0;
            r_sec_cnt  <= '0;
        end else if (i_en) begin
            if (r_tick_cnt == ONE_SECOND_CNT) begin
                r_tick_cnt <= '0;
                if (r_sec_cnt != '1) begin
                    r_sec_cnt <= r_sec_cnt + SEC_W'(1);
                end
            end else begin
                r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
        end
    end

    assign o_sec_cnt = r_sec_cnt;

endmodule

// File: rtl/si_req_ctrl.sv
// si_req_ctrl: SI-get request initiator. Serialises an 18-byte request onto
// the responder command port, then parses the reply stream (header check,
// payload forwarding, null reply, watchdog) and reports one status per request.
// Optional feature macro: SI_REQ_LEN_CHECK_EN (section_length vs payload count).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_start, req_*             request pulse and fields (sampled in IDLE)
//   con_dout, con_dout_en        command byte stream to the responder
//   si_din, si_din_en            reply byte stream from the responder
//   sec_dout, sec_dout_en        section payload bytes
//   sec_last                     marks the final payload byte
//   rsp_pkt_no, rsp_pkt_total    reply header fields, valid from done
//   done, status                 one-cycle completion pulse and status code
//   busy                         request in progress
module si_req_ctrl
    import si_req_pkg::*;
#(
    parameter logic [TICK_W-1:0] ONE_SECOND_CNT = 28'h9502F90,
    parameter int unsigned       WD_MARGIN      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_start,
    input  logic [7:0]  req_cmd_no,
    input  logic [7:0]  req_reply,
    input  logic [15:0] req_pkt_no,
    input  logic [15:0] req_pkt_total,
    input  logic [7:0]  req_sfp_num,
    input  logic [31:0] req_ip,
    input  logic [15:0] req_port,
    input  logic [12:0] req_pid,
    input  logic [7:0]  req_table_id,
    input  logic [7:0]  req_sec_num,
    input  logic [7:0]  req_over_time,
    output logic [7:0]  con_dout,
    output logic        con_dout_en,
    input  logic [7:0]  si_din,
    input  logic        si_din_en,
    output logic [7:0]  sec_dout,
    output logic        sec_dout_en,
    output logic        sec_last,
    output logic [15:0] rsp_pkt_no,
    output logic [15:0] rsp_pkt_total,
    output logic        done,
    output logic [2:0]  status,
    output logic        busy
);

    si_state_e                   r_state, w_state;
    si_req_t                     r_req, w_req, w_req_in;
    logic [BYTE_CNT_W-1:0]       r_byte_cnt, w_byte_cnt;
    logic [HDR_LEN-1:0][7:0]     r_hdr, w_hdr;
    logic [HDR_CNT_W-1:0]        r_hdr_cnt, w_hdr_cnt;
    logic [7:0]                  r_hold, w_hold;
    logic                        r_hold_vld, w_hold_vld;
    logic [PAY_CNT_W-1:0]        r_pay_cnt, w_pay_cnt;
    logic                        r_din_en_d;
`ifdef SI_REQ_LEN_CHECK_EN
    logic [SEC_LEN_W-1:0]        r_sec_len, w_sec_len;
`endif

    logic [7:0]                  r_con_dout, w_con_dout;
    logic                        r_con_dout_en, w_con_dout_en;
    logic [7:0]                  r_sec_dout, w_sec_dout;
    logic                        r_sec_dout_en, w_sec_dout_en;
    logic                        r_sec_last, w_sec_last;
    logic [15:0]                 r_rsp_pkt_no, w_rsp_pkt_no;
    logic [15:0]                 r_rsp_pkt_total, w_rsp_pkt_total;
    logic                        r_done, w_done;
    si_status_e                  r_status, w_status;
    logic                        r_busy, w_busy;

    logic                        w_fin;
    si_status_e                  w_fin_status;
    logic [SEC_W-1:0]            w_sec_cnt;
    logic                        w_wd_hit;
    logic                        w_hdr_null;
    logic                        w_frame_rise;
    logic                        w_tmr_clr;
    logic                        w_tmr_en;

    assign w_req_in = '{
        cmd_no:    req_cmd_no,
        reply:     req_reply,
        pkt_no:    req_pkt_no,
        pkt_total: req_pkt_total,
        sfp_num:   req_sfp_num,
        ip:        req_ip,
        port:      req_port,
        pid:       req_pid,
        table_id:  req_table_id,
        sec_num:   req_sec_num,
        over_time: req_over_time
    };

    // Watchdog only counts while waiting for the first reply byte.
    assign w_tmr_clr = (r_state != WAIT_REPLY);
    assign w_tmr_en  = (r_state == WAIT_REPLY);

    si_sec_timer #(
        .ONE_SECOND_CNT (ONE_SECOND_CNT)
    ) u_sec_timer (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_sec_cnt (w_sec_cnt)
    );

    // 9-bit compare so over_time near 255 cannot wrap into an early timeout.
    assign w_wd_hit = ({1'b0, w_sec_cnt} ==
                       (9'(r_req.over_time) + 9'(WD_MARGIN)));

    assign w_hdr_null = (r_hdr[0] == NULL_BYTE) && (r_hdr[1] == NULL_BYTE) &&
                        (r_hdr[2] == NULL_BYTE) && (r_hdr[3] == NULL_BYTE);

    // Only a rising edge starts a frame, so a frame already in flight is skipped.
    assign w_frame_rise = si_din_en && !r_din_en_d;

    // Next-state and next-output logic.
    always_comb begin
        w_state         = r_state;
        w_req           = r_req;
        w_byte_cnt      = r_byte_cnt;
        w_hdr           = r_hdr;
        w_hdr_cnt       = r_hdr_cnt;
        w_hold          = r_hold;
        w_hold_vld      = r_hold_vld;
        w_pay_cnt       = r_pay_cnt;
`ifdef SI_REQ_LEN_CHECK_EN
        w_sec_len       = r_sec_len;
`endif
        w_con_dout      = 8'h00;
        w_con_dout_en   = 1'b0;
        w_sec_dout      = 8'h00;
        w_sec_dout_en   = 1'b0;
        w_sec_last      = 1'b0;
        w_rsp_pkt_no    = r_rsp_pkt_no;
        w_rsp_pkt_total = r_rsp_pkt_total;
        w_done          = 1'b0;
        w_status        = r_status;
        w_fin           = 1'b0;
        w_fin_status    = STAT_OK;

        case (r_state)
            IDLE: begin
                if (req_start) begin
                    w_req         = w_req_in;
                    w_con_dout    = cmd_byte(w_req_in, BYTE_CNT_W'(0));
                    w_con_dout_en = 1'b1;
                    w_byte_cnt    = BYTE_CNT_W'(1);
                    w_hdr         = '0;
                    w_hdr_cnt     = '0;
                    w_hold_vld    = 1'b0;
                    w_pay_cnt     = '0;
`ifdef SI_REQ_LEN_CHECK_EN
                    w_sec_len     = '0;
`endif
                    w_state       = CMD_SEND;
                end
            end

            CMD_SEND: begin
                w_con_dout    = cmd_byte(r_req, r_byte_cnt);
                w_con_dout_en = 1'b1;
                w_byte_cnt    = r_byte_cnt + BYTE_CNT_W'(1);
                if (r_byte_cnt == BYTE_CNT_W'(CMD_LEN - 1)) begin
                    w_state = WAIT_REPLY;
                end
            end

            WAIT_REPLY: begin
                // A reply byte in the watchdog-hit cycle takes priority.
                if (w_frame_rise) begin
                    w_hdr[0]  = si_din;
                    w_hdr_cnt = HDR_CNT_W'(1);
                    w_state   = RX_HEAD;
                end else if (w_wd_hit) begin
                    w_fin        = 1'b1;
                    w_fin_status = STAT_TIMEOUT;
                end
            end

            RX_HEAD: begin
                if (si_din_en) begin
                    w_hdr[r_hdr_cnt] = si_din;
                    w_hdr_cnt        = r_hdr_cnt + HDR_CNT_W'(1);
                    if (r_hdr_cnt == HDR_CNT_W'(HDR_LEN - 1)) begin
                        w_state = (r_hdr[0] != r_req.cmd_no) ? DRAIN : RX_DATA;
                    end
                end else begin
                    w_fin        = 1'b1;
                    w_fin_status = ((r_hdr_cnt == HDR_CNT_W'(NULL_LEN)) && w_hdr_null)
                                   ? STAT_NULL : STAT_HDR_ERR;
                end
            end

            DRAIN: begin
                if (!si_din_en) begin
                    w_fin        = 1'b1;
                    w_fin_status = STAT_HDR_ERR;
                end
            end

            RX_DATA: begin
                // One-byte hold lets the final byte carry sec_last.
                if (si_din_en) begin
                    if (r_hold_vld) begin
                        w_sec_dout    = r_hold;
                        w_sec_dout_en = 1'b1;
                    end
                    w_hold     = si_din;
                    w_hold_vld = 1'b1;
                    w_pay_cnt  = r_pay_cnt + PAY_CNT_W'(1);
`ifdef SI_REQ_LEN_CHECK_EN
                    if (r_pay_cnt == PAY_CNT_W'(1)) begin
                        w_sec_len[11:8] = si_din[3:0];
                    end
                    if (r_pay_cnt == PAY_CNT_W'(2)) begin
                        w_sec_len[7:0] = si_din;
                    end
`endif
                end else begin
                    if (r_hold_vld) begin
                        w_sec_dout    = r_hold;
                        w_sec_dout_en = 1'b1;
                        w_sec_last    = 1'b1;
                    end
                    w_hold_vld = 1'b0;
                    w_fin      = 1'b1;
`ifdef SI_REQ_LEN_CHECK_EN
                    // A header-only reply carries no section, so nothing to check.
                    if ((r_pay_cnt != '0) &&
                        (r_pay_cnt != (PAY_CNT_W'(r_sec_len) + PAY_CNT_W'(3)))) begin
                        w_fin_status = STAT_LEN_ERR;
                    end else begin
                        w_fin_status = STAT_OK;
                    end
`else
                    w_fin_status = STAT_OK;
`endif
                end
            end

            DONE: begin
                w_state = IDLE;
            end

            default: begin
                w_state = IDLE;
            end
        endcase

        if (w_fin) begin
            w_state         = DONE;
            w_done          = 1'b1;
            w_status        = w_fin_status;
            w_rsp_pkt_no    = {r_hdr[2], r_hdr[3]};
            w_rsp_pkt_total = {r_hdr[4], r_hdr[5]};
        end

        w_busy = (w_state != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_req           <= '0;
            r_byte_cnt      <= '0;
            r_hdr           <= '0;
            r_hdr_cnt       <= '0;
            r_hold          <= '0;
            r_hold_vld      <= 1'b0;
            r_pay_cnt       <= '0;
            r_din_en_d      <= 1'b0;
`ifdef SI_REQ_LEN_CHECK_EN
            r_sec_len       <= '0;
`endif
            r_con_dout      <= '0;
            r_con_dout_en   <= 1'b0;
            r_sec_dout      <= '0;
            r_sec_dout_en   <= 1'b0;
            r_sec_last      <= 1'b0;
            r_rsp_pkt_no    <= '0;
            r_rsp_pkt_total <= '0;
            r_done          <= 1'b0;
            r_status        <= STAT_OK;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state;
            r_req           <= w_req;
            r_byte_cnt      <= w_byte_cnt;
            r_hdr           <= w_hdr;
            r_hdr_cnt       <= w_hdr_cnt;
            r_hold          <= w_hold;
            r_hold_vld      <= w_hold_vld;
            r_pay_cnt       <= w_pay_cnt;
            r_din_en_d      <= si_din_en;
`ifdef SI_REQ_LEN_CHECK_EN
            r_sec_len       <= w_sec_len;
`endif
            r_con_dout      <= w_con_dout;
            r_con_dout_en   <= w_con_dout_en;
            r_sec_dout      <= w_sec_dout;
            r_sec_dout_en   <= w_sec_dout_en;
            r_sec_last      <= w_sec_last;
            r_rsp_pkt_no    <= w_rsp_pkt_no;
            r_rsp_pkt_total <= w_rsp_pkt_total;
            r_done          <= w_done;
            r_status        <= w_status;
            r_busy          <= w_busy;
        end
    end

    assign con_dout      = r_con_dout;
    assign con_dout_en   = r_con_dout_en;
    assign sec_dout      = r_sec_dout;
    assign sec_dout_en   = r_sec_dout_en;
    assign sec_last      = r_sec_last;
    assign rsp_pkt_no    = r_rsp_pkt_no;
    assign rsp_pkt_total = r_rsp_pkt_total;
    assign done          = r_done;
    assign status        = r_status;
    assign busy          = r_busy;

endmodule
